nand_serial_sequencer: RTL and testbench

//   Multi-cycle controller that computes NOT/AND/OR/XOR over WIDTH-bit operands using one shared 2-input

---
 rtl/nand_serial_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_nand_serial_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_serial_sequencer.sv
// nand_serial_sequencer: computes NOT/AND/OR/XOR over WIDTH-bit operands by
// time-multiplexing a single 2-input nand primitive, one evaluation per cycle,
// LSB first. Each bit takes (op + 1) gate steps; intermediate terms live in
// registered temps t0..t2.
module nand_serial_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned STEP_W = 2;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Opcode value doubles as the index of the final step for that operation.
    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                t0_q, t0_d;
    logic                t1_q, t1_d;
    logic                t2_q, t2_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                ai_c;
    logic                bi_c;
    logic                gate_x_c;
    logic                gate_y_c;
    logic                r_c;
    logic                last_step_c;

    // Current operand bits from the captured operands.
    always_comb begin
        ai_c = a_q[bit_q];
        bi_c = b_q[bit_q];
    end

    // Route operand bits / temps into the shared gate for the current step.
    always_comb begin
        gate_x_c = 1'b0;
        gate_y_c = 1'b0;
        case (op_q)
            OP_NOT: begin
                gate_x_c = ai_c;
                gate_y_c = ai_c;
            end
            OP_AND: begin
                case (step_q)
                    2'd0:    begin gate_x_c = ai_c; gate_y_c = bi_c; end
                    default: begin gate_x_c = t0_q; gate_y_c = t0_q; end
                endcase
            end
            OP_OR: begin
                case (step_q)
                    2'd0:    begin gate_x_c = ai_c; gate_y_c = ai_c; end
                    2'd1:    begin gate_x_c = bi_c; gate_y_c = bi_c; end
                    default: begin gate_x_c = t0_q; gate_y_c = t1_q; end
                endcase
            end
            default: begin
                case (step_q)
                    2'd0:    begin gate_x_c = ai_c; gate_y_c = bi_c; end
                    2'd1:    begin gate_x_c = ai_c; gate_y_c = t0_q; end
                    2'd2:    begin gate_x_c = bi_c; gate_y_c = t0_q; end
                    default: begin gate_x_c = t1_q; gate_y_c = t2_q; end
                endcase
            end
        endcase
    end

    // The single shared gate.
    nand u_nand (r_c, gate_x_c, gate_y_c);

    // Final step of a bit is reached when the step index equals the opcode.
    always_comb begin
        last_step_c = (step_q == STEP_W'(op_q));
    end

    // Next-state, counter, temp and result update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        bit_d   = bit_q;
        step_d  = step_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    bit_d   = '0;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step_c) begin
                    out_d[bit_q] = r_c;
                    step_d       = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = BIT_W'(bit_q + 1'b1);
                    end
                end else begin
                    step_d = STEP_W'(step_q + 1'b1);
                    case (step_q)
                        2'd0:    t0_d = r_c;
                        2'd1:    t1_d = r_c;
                        default: t2_d = r_c;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOT;
            a_q     <= '0;
            b_q     <= '0;
            bit_q   <= '0;
            step_q  <= '0;
            t0_q    <= 1'b0;
            t1_q    <= 1'b0;
            t2_q    <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bit_q   <= bit_d;
            step_q  <= step_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Registered outputs.
    always_comb begin
        busy = busy_q;
        done = done_q;
        out  = out_q;
    end

endmodule

// File: tb/tb_nand_serial_sequencer.sv
// Directed bench for nand_serial_sequencer (WIDTH=8).
module tb_nand_serial_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] out;

    int total;
    int bad;

    nand_serial_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and clock it in (edge E).
    task automatic launch(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        tick();
    endtask

    // Observe a run after launch: edges to done, busy cycles, result, and the cycle after done.
    task automatic measure(input bit hold, output int lat, output int busy_cnt,
                           output logic [7:0] res, output logic done_after, output logic busy_after);
        if (!hold) start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        res = 8'hxx;
        while (lat < 200) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
            if (done) begin
                res = out;
                break;
            end
        end
        tick();
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
        tick(); tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_not();
        int lat, bc; logic [7:0] r; logic da, ba;
        launch(2'b00, 8'hA5, 8'h00);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL not_busy_at_E got=%b exp=1", busy); end
        measure(1'b0, lat, bc, r, da, ba);
        total++; if (lat !== 8) begin bad++; $display("FAIL not_latency got=%0d exp=8", lat); end
        total++; if (r !== 8'h5A) begin bad++; $display("FAIL not_out got=%h exp=5a", r); end
        total++; if (bc !== 9) begin bad++; $display("FAIL not_busy_cycles got=%0d exp=9", bc); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL not_busy_after got=%b exp=0", ba); end
    endtask

    task automatic test_and();
        int lat, bc; logic [7:0] r; logic da, ba;
        launch(2'b01, 8'hF0, 8'h3C);
        measure(1'b0, lat, bc, r, da, ba);
        total++; if (lat !== 16) begin bad++; $display("FAIL and_latency got=%0d exp=16", lat); end
        total++; if (r !== 8'h30) begin bad++; $display("FAIL and_out got=%h exp=30", r); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL and_done_pulse got=%b exp=0", da); end
        total++; if (out !== 8'h30) begin bad++; $display("FAIL and_out_hold got=%h exp=30", out); end
    endtask

    task automatic test_or();
        int lat, bc; logic [7:0] r; logic da, ba;
        launch(2'b10, 8'hF0, 8'h0F);
        measure(1'b0, lat, bc, r, da, ba);
        total++; if (lat !== 24) begin bad++; $display("FAIL or_latency got=%0d exp=24", lat); end
        total++; if (r !== 8'hFF) begin bad++; $display("FAIL or_out got=%h exp=ff", r); end
        total++; if (bc !== 25) begin bad++; $display("FAIL or_busy_cycles got=%0d exp=25", bc); end
        launch(2'b10, 8'h00, 8'h00);
        measure(1'b0, lat, bc, r, da, ba);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL or_zero_out got=%h exp=00", r); end
        total++; if (lat !== 24) begin bad++; $display("FAIL or_zero_latency got=%0d exp=24", lat); end
    endtask

    task automatic test_xor();
        int early;
        logic seen;
        early = 0; seen = 1'b0;
        launch(2'b11, 8'hAA, 8'hFF);
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 10) begin a = 8'h00; b = 8'h00; op = 2'b01; end
            if (k < 32 && done) early++;
            if (k == 32) seen = done;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL xor_early_done got=%0d exp=0", early); end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL xor_done_edge32 got=%b exp=1", seen); end
        total++; if (out !== 8'h55) begin bad++; $display("FAIL xor_out got=%h exp=55", out); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL xor_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_start_while_busy();
        int dones, done_at;
        dones = 0; done_at = 0;
        launch(2'b11, 8'h3C, 8'h0F);
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin start = 1'b1; op = 2'b00; end
            if (k == 6) start = 1'b0;
            tick();
            if (done) begin dones++; done_at = k; start = 1'b1; end
            else if (k > 6) start = 1'b0;
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        total++; if (done_at !== 32) begin bad++; $display("FAIL busy_start_latency got=%0d exp=32", done_at); end
        total++; if (out !== 8'h33) begin bad++; $display("FAIL busy_start_out got=%h exp=33", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dones; logic [7:0] r; logic da, ba;
        dones = 0;
        launch(2'b11, 8'hAA, 8'hFF);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%h exp=00", out); end
        for (int k = 0; k < 30; k++) begin
            if (done) dones++;
            tick();
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", dones); end
        launch(2'b01, 8'hFF, 8'h0F);
        measure(1'b0, lat, bc, r, da, ba);
        total++; if (r !== 8'h0F) begin bad++; $display("FAIL rst_fresh_and got=%h exp=0f", r); end
        total++; if (lat !== 16) begin bad++; $display("FAIL rst_fresh_latency got=%0d exp=16", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, lat2; logic [7:0] r; logic da, ba;
        launch(2'b00, 8'h00, 8'h00);
        measure(1'b1, lat, bc, r, da, ba);
        total++; if (r !== 8'hFF) begin bad++; $display("FAIL b2b_out1 got=%h exp=ff", r); end
        total++; if (lat !== 8) begin bad++; $display("FAIL b2b_latency1 got=%0d exp=8", lat); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b exp=0", ba); end
        a = 8'h0F;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%b exp=1", busy); end
        start = 1'b0;
        lat2 = 0;
        while (lat2 < 200) begin
            tick();
            lat2++;
            if (done) break;
        end
        total++; if (lat2 !== 8) begin bad++; $display("FAIL b2b_latency2 got=%0d exp=8", lat2); end
        total++; if (out !== 8'hF0) begin bad++; $display("FAIL b2b_out2 got=%h exp=f0", out); end
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle got=%b exp=0", busy); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
        test_reset();
        test_not();
        test_and();
        test_or();
        test_xor();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
